pipe_stage_buf: RTL

- Generic, parametrised inter-stage pipeline register for the CPU pipeline (IF/ID/EXE/MEM/WB boundaries), carrying an opaque payload bus of WIDTH bits.
- Generalises the per-stage hand-coded registers with a valid/allow_in handshake, an optional skid entry that registers in_allow_in, and exception/ertn flush.
- Adds a saturating stall counter for performance debug.

---
 rtl/pipe_stage_buf_if.sv | 11 +
 rtl/pipe_stage_buf.sv | 97 +++++++++
 2 files changed

// File: rtl/pipe_stage_buf_if.sv
// Valid/allow_in/payload handshake bundle between adjacent pipeline stages.
interface pipe_stage_buf_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid;
  logic             allow_in;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input allow_in);
  modport slave  (input valid, input data, output allow_in);
endinterface

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with optional skid entry, flush and a
// saturating stall counter for performance debug.
module pipe_stage_buf #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned SKID           = 1,
  parameter int unsigned CLEAR_ON_FLUSH = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_buf_if.slave  in_if,
  pipe_stage_buf_if.master out_if,
  input  logic             stage_ready_go,
  output logic             stage_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [WIDTH-1:0] r_main;
  logic             r_main_valid;
  logic [WIDTH-1:0] r_skid;
  logic             r_skid_valid;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_out_fire;
  logic w_in_fire;
  logic w_allow_in;
  logic w_main_free;

  assign w_out_fire  = r_main_valid & stage_ready_go & out_if.allow_in;
  // With a skid entry, allow_in depends only on state, breaking the
  // combinational path from downstream allow_in back upstream.
  assign w_allow_in  = (SKID != 0) ? ~r_skid_valid
                                   : (~r_main_valid | (stage_ready_go & out_if.allow_in));
  assign w_in_fire   = in_if.valid & w_allow_in;
  assign w_main_free = ~r_main_valid | w_out_fire;

  assign in_if.allow_in = w_allow_in;
  assign out_if.valid   = r_main_valid & stage_ready_go;
  assign out_if.data    = r_main;
  assign stage_valid    = r_main_valid;
  assign stall_cnt      = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main       <= '0;
      r_main_valid <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      if (CLEAR_ON_FLUSH != 0) begin
        r_main <= '0;
        r_skid <= '0;
      end
    end else if (SKID != 0) begin
      if (w_main_free) begin
        if (r_skid_valid) begin
          r_main       <= r_skid;
          r_main_valid <= 1'b1;
          if (w_in_fire) begin
            r_skid       <= in_if.data;
            r_skid_valid <= 1'b1;
          end else begin
            r_skid_valid <= 1'b0;
          end
        end else if (w_in_fire) begin
          r_main       <= in_if.data;
          r_main_valid <= 1'b1;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_in_fire) begin
        r_skid       <= in_if.data;
        r_skid_valid <= 1'b1;
      end
    end else begin
      if (w_in_fire) begin
        r_main       <= in_if.data;
        r_main_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_main_valid <= 1'b0;
      end
    end
  end

  // Counts every occupied cycle that does not drain, flush or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid && !w_out_fire && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
